// File: rtl/ff_bank_counter.sv
// ============================================================================
// Module   : ff_bank_counter
// Brief    : WIDTH-bit bank usable as per-bit J-K/T flip-flops, a parallel-load
//            register, or a modulo-MODULUS up/down counter (wrap or saturate).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_bank_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_,
  output logic             TC,
  output logic             EVT
);

  localparam logic [2:0]       c_MODE_JK   = 3'b000;
  localparam logic [2:0]       c_MODE_T    = 3'b001;
  localparam logic [2:0]       c_MODE_LOAD = 3'b010;
  localparam logic [2:0]       c_MODE_UP   = 3'b011;
  localparam logic [2:0]       c_MODE_DOWN = 3'b100;
  // Top count value; with MODULUS = 2**WIDTH this is all ones, so wrap is natural overflow.
  localparam logic [WIDTH-1:0] c_MAX       = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_evt;
  logic [WIDTH-1:0] w_q_next;
  logic             w_evt_next;
  logic             w_at_top;
  logic             w_at_zero;

  assign w_at_top  = (r_q >= c_MAX);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_q_next   = r_q;
    w_evt_next = 1'b0;
    case (MODE)
      c_MODE_JK:   w_q_next = (J & ~r_q) | (~K & r_q);
      c_MODE_T:    w_q_next = r_q ^ J;
      c_MODE_LOAD: w_q_next = D;
      c_MODE_UP: begin
        if (w_at_top) begin
          w_evt_next = 1'b1;
          w_q_next   = SATURATE ? r_q : '0;
        end else begin
          w_q_next   = r_q + c_ONE;
        end
      end
      c_MODE_DOWN: begin
        if (w_at_zero) begin
          w_evt_next = 1'b1;
          w_q_next   = SATURATE ? r_q : c_MAX;
        end else if (r_q > c_MAX) begin
          // Out-of-range loaded values snap back into range without an event.
          w_q_next   = c_MAX;
        end else begin
          w_q_next   = r_q - c_ONE;
        end
      end
      default: begin
        w_q_next   = r_q;
        w_evt_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      r_q   <= '0;
      r_evt <= 1'b0;
    end else if (EN) begin
      r_q   <= w_q_next;
      r_evt <= w_evt_next;
    end else begin
      r_evt <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign Q_  = ~r_q;
  assign EVT = r_evt;
  assign TC  = ((MODE == c_MODE_UP) && w_at_top) || ((MODE == c_MODE_DOWN) && w_at_zero);

endmodule

`default_nettype wire

// File: tb/tb_ff_bank_counter.sv
// ============================================================================
// Module   : tb_ff_bank_counter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against an integer reference model, over four parameterisations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_bank_counter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] mode, mode1;
  logic [7:0] j, k, d;
  logic [0:0] j1, k1, d1;

  logic [7:0] q8, qn8, q10, qn10, qs, qns;
  logic       tc8, evt8, tc10, evt10, tcs, evts;
  logic [0:0] q1, qn1;
  logic       tc1, evt1;

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 = default 8-bit, 1 = mod 10, 2 = mod 10 saturating, 3 = 1-bit
  int mq [4];
  bit me [4];
  int mods  [4] = '{256, 10, 10, 2};
  bit sats  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int wids  [4] = '{8, 8, 8, 1};

  ff_bank_counter u8 (
    .CK(clk), .RESET(rst), .EN(en), .MODE(mode), .J(j), .K(k), .D(d),
    .Q(q8), .Q_(qn8), .TC(tc8), .EVT(evt8)
  );
  ff_bank_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b0)) u10 (
    .CK(clk), .RESET(rst), .EN(en), .MODE(mode), .J(j), .K(k), .D(d),
    .Q(q10), .Q_(qn10), .TC(tc10), .EVT(evt10)
  );
  ff_bank_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1'b1)) us (
    .CK(clk), .RESET(rst), .EN(en), .MODE(mode), .J(j), .K(k), .D(d),
    .Q(qs), .Q_(qns), .TC(tcs), .EVT(evts)
  );
  ff_bank_counter #(.WIDTH(1)) u1 (
    .CK(clk), .RESET(rst), .EN(en), .MODE(mode1), .J(j1), .K(k1), .D(d1),
    .Q(q1), .Q_(qn1), .TC(tc1), .EVT(evt1)
  );

  always #5 clk = ~clk;

  function automatic int model_next(input int q, input int w, input int md, input bit sat,
                                    input bit r, input bit e, input int mo,
                                    input int ji, input int ki, input int di,
                                    output bit ev);
    int n;
    n  = q;
    ev = 1'b0;
    if (r) return 0;
    if (!e) return q;
    case (mo)
      0: for (int b = 0; b < w; b++) begin
           if (((ji >> b) & 1) == 1 && ((ki >> b) & 1) == 1) n = n ^ (1 << b);
           else if (((ji >> b) & 1) == 1) n = n | (1 << b);
           else if (((ki >> b) & 1) == 1) n = n & ~(1 << b);
         end
      1: n = q ^ ji;
      2: n = di;
      3: if (q >= md - 1) begin ev = 1'b1; n = sat ? q : 0; end
         else n = q + 1;
      4: if (q == 0) begin ev = 1'b1; n = sat ? 0 : md - 1; end
         else if (q >= md) n = md - 1;
         else n = q - 1;
      default: n = q;
    endcase
    return n & ((1 << w) - 1);
  endfunction

  function automatic bit model_tc(input int i, input int mo);
    return (mo == 3 && mq[i] >= mods[i] - 1) || (mo == 4 && mq[i] == 0);
  endfunction

  task automatic cycle();
    bit ev;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mq[i] = model_next(mq[i], wids[i], mods[i], sats[i], rst, en, int'(mode),
                         int'(j), int'(k), int'(d), ev);
      me[i] = ev;
    end
    mq[3] = model_next(mq[3], 1, 2, 1'b0, rst, en, int'(mode1),
                       int'(j1), int'(k1), int'(d1), ev);
    me[3] = ev;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'b011; mode1 = 3'b000;
    j = '0; k = '0; d = '0; j1 = '0; k1 = '0; d1 = '0;
    cycle();
    rst = 1'b0;
    total++;
    if (q8 !== 8'h00 || qn8 !== 8'hFF || evt8 !== 1'b0) begin
      bad++; $display("FAIL reset8 q=%h q_=%h evt=%b exp q=00 q_=FF evt=0", q8, qn8, evt8);
    end
    total++;
    if (q10 !== 8'h00 || qs !== 8'h00 || q1 !== 1'b0 || qn1 !== 1'b1) begin
      bad++; $display("FAIL reset_all q10=%h qs=%h q1=%b q1_=%b exp 00 00 0 1", q10, qs, q1, qn1);
    end
  endtask

  task automatic test_jk();
    en = 1'b1; mode = 3'b000;
    j = 8'hF0; k = 8'h0F; cycle();
    total++;
    if (q8 !== 8'hF0) begin bad++; $display("FAIL jk_setclr q=%h exp=f0", q8); end
    j = 8'hFF; k = 8'hFF; cycle();
    total++;
    if (q8 !== 8'h0F || qn8 !== 8'hF0) begin bad++; $display("FAIL jk_toggle q=%h q_=%h exp=0f f0", q8, qn8); end
    j = 8'h00; k = 8'h00; cycle();
    total++;
    if (q8 !== 8'h0F) begin bad++; $display("FAIL jk_hold q=%h exp=0f", q8); end
  endtask

  task automatic test_t_load();
    mode = 3'b010; d = 8'hA5; cycle();
    total++;
    if (q8 !== 8'hA5) begin bad++; $display("FAIL load q=%h exp=a5", q8); end
    mode = 3'b001; j = 8'h0F; cycle();
    total++;
    if (q8 !== 8'hAA) begin bad++; $display("FAIL t_toggle q=%h exp=aa", q8); end
    en = 1'b0; j = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      cycle();
      total++;
      if (q8 !== 8'hAA || evt8 !== 1'b0) begin
        bad++; $display("FAIL en_hold%0d q=%h evt=%b exp=aa 0", n, q8, evt8);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_wrap_up();
    mode = 3'b010; d = 8'd7; cycle();
    mode = 3'b011; cycle();
    total++;
    if (q10 !== 8'd8 || tc10 !== 1'b0) begin bad++; $display("FAIL up8 q=%0d tc=%b exp=8 0", q10, tc10); end
    cycle();
    total++;
    if (q10 !== 8'd9 || tc10 !== 1'b1) begin bad++; $display("FAIL up9 q=%0d tc=%b exp=9 1", q10, tc10); end
    cycle();
    total++;
    if (q10 !== 8'd0 || evt10 !== 1'b1) begin bad++; $display("FAIL up_wrap q=%0d evt=%b exp=0 1", q10, evt10); end
    cycle();
    total++;
    if (q10 !== 8'd1 || evt10 !== 1'b0) begin bad++; $display("FAIL up_after q=%0d evt=%b exp=1 0", q10, evt10); end
  endtask

  task automatic test_wrap_down();
    mode = 3'b010; d = 8'd1; cycle();
    mode = 3'b100; cycle();
    total++;
    if (q10 !== 8'd0 || tc10 !== 1'b1) begin bad++; $display("FAIL dn0 q=%0d tc=%b exp=0 1", q10, tc10); end
    cycle();
    total++;
    if (q10 !== 8'd9 || evt10 !== 1'b1) begin bad++; $display("FAIL dn_wrap q=%0d evt=%b exp=9 1", q10, evt10); end
    mode = 3'b010; d = 8'd12; cycle();
    total++;
    if (q10 !== 8'd12) begin bad++; $display("FAIL load_oor q=%0d exp=12", q10); end
    mode = 3'b100; cycle();
    total++;
    if (q10 !== 8'd9 || evt10 !== 1'b0) begin bad++; $display("FAIL dn_oor q=%0d evt=%b exp=9 0", q10, evt10); end
  endtask

  task automatic test_saturate();
    mode = 3'b010; d = 8'd8; cycle();
    mode = 3'b011; cycle();
    total++;
    if (qs !== 8'd9 || evts !== 1'b0) begin bad++; $display("FAIL sat_up9 q=%0d evt=%b exp=9 0", qs, evts); end
    for (int n = 0; n < 2; n++) begin
      cycle();
      total++;
      if (qs !== 8'd9 || evts !== 1'b1 || tcs !== 1'b1) begin
        bad++; $display("FAIL sat_hold%0d q=%0d evt=%b tc=%b exp=9 1 1", n, qs, evts, tcs);
      end
    end
    mode = 3'b010; d = 8'd0; cycle();
    mode = 3'b100; cycle();
    total++;
    if (qs !== 8'd0 || evts !== 1'b1 || tcs !== 1'b1) begin
      bad++; $display("FAIL sat_dn q=%0d evt=%b tc=%b exp=0 1 1", qs, evts, tcs);
    end
  endtask

  task automatic test_reset_mid();
    mode = 3'b010; d = 8'd5; cycle();
    mode = 3'b011; rst = 1'b1; cycle();
    total++;
    if (q10 !== 8'd0 || evt10 !== 1'b0) begin bad++; $display("FAIL rst_mid q=%0d evt=%b exp=0 0", q10, evt10); end
    rst = 1'b0; cycle();
    total++;
    if (q10 !== 8'd1) begin bad++; $display("FAIL rst_resume1 q=%0d exp=1", q10); end
    cycle();
    total++;
    if (q10 !== 8'd2) begin bad++; $display("FAIL rst_resume2 q=%0d exp=2", q10); end
  endtask

  task automatic test_width1();
    bit exp_q;
    rst = 1'b1; cycle(); rst = 1'b0;
    mode1 = 3'b011;
    exp_q = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cycle();
      total++;
      if (q1 !== ~exp_q || evt1 !== exp_q || tc1 !== ~exp_q) begin
        bad++; $display("FAIL w1_step%0d q=%b evt=%b tc=%b exp=%b %b %b", n, q1, evt1, tc1, ~exp_q, exp_q, ~exp_q);
      end
      exp_q = ~exp_q;
    end
  endtask

  task automatic test_random();
    logic [7:0] eq;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      mode  = 3'($urandom_range(0, 7));
      mode1 = 3'($urandom_range(0, 7));
      j = 8'($urandom); k = 8'($urandom); d = 8'($urandom);
      j1 = 1'($urandom); k1 = 1'($urandom); d1 = 1'($urandom);
      // Bias toward counting modes so wrap/saturate edges are reached often.
      if ($urandom_range(0, 1) == 1) mode = 3'($urandom_range(3, 4));
      cycle();
      for (int i = 0; i < 3; i++) begin
        eq = 8'(mq[i]);
        total++;
        case (i)
          0: if ({q8, qn8, tc8, evt8} !== {eq, ~eq, model_tc(0, int'(mode)), me[0]}) begin
               bad++; $display("FAIL rnd8 n=%0d q=%h tc=%b evt=%b exp=%h %b %b", n, q8, tc8, evt8, eq, model_tc(0, int'(mode)), me[0]);
             end
          1: if ({q10, qn10, tc10, evt10} !== {eq, ~eq, model_tc(1, int'(mode)), me[1]}) begin
               bad++; $display("FAIL rnd10 n=%0d q=%h tc=%b evt=%b exp=%h %b %b", n, q10, tc10, evt10, eq, model_tc(1, int'(mode)), me[1]);
             end
          default: if ({qs, qns, tcs, evts} !== {eq, ~eq, model_tc(2, int'(mode)), me[2]}) begin
               bad++; $display("FAIL rndsat n=%0d q=%h tc=%b evt=%b exp=%h %b %b", n, qs, tcs, evts, eq, model_tc(2, int'(mode)), me[2]);
             end
        endcase
      end
      total++;
      if ({q1, qn1, tc1, evt1} !== {1'(mq[3]), ~1'(mq[3]), model_tc(3, int'(mode1)), me[3]}) begin
        bad++; $display("FAIL rnd1 n=%0d q=%b tc=%b evt=%b exp=%b %b %b", n, q1, tc1, evt1, 1'(mq[3]), model_tc(3, int'(mode1)), me[3]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mq[i] = 0; me[i] = 1'b0; end
    test_reset();
    test_jk();
    test_t_load();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_reset_mid();
    test_width1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ff_bank_counter.md
# ff_bank_counter

Parametrised multi-mode register bank: WIDTH bits that each behave as a J-K or T flip-flop, or that together form a parallel-load register or a modulo-N up/down counter. It is the successor to the single-bit J-K/T flip-flop primitives. It serves the game logic's score counters, paddle/ball position registers and frame dividers from one block. All state updates on the rising edge of CK.

## Interface
Parameters:
- WIDTH, 8, number of bits in the bank (≥1)
- MODULUS, 2**WIDTH, count range for counter modes; legal values 2..2**WIDTH
- SATURATE, 0, 0 = counters wrap at the ends, 1 = counters stick at the ends

Ports:
- CK  input  1  clock, rising-edge active
- RESET  input  1  synchronous, active-high reset; one clock, reset polarity/synchronicity fixed
- EN  input  1  update enable; when 0 every output holds (EVT forced 0)
- MODE  input  3  operating mode, encoding below
- J  input  WIDTH  per-bit J (JK mode), per-bit T (T mode)
- K  input  WIDTH  per-bit K (JK mode)
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  bank state
- Q_  output  WIDTH  bitwise complement of Q, always ~Q (including during/after reset)
- TC  output  1  combinational terminal-count flag
- EVT  output  1  registered one-cycle pulse, 1 when the previous update wrapped or saturated

## Operation
- MODE 000 JK: per bit i, J=0/K=0 hold, J=1/K=0 set, J=0/K=1 clear, J=1/K=1 toggle. K is ignored in all other modes.
- MODE 001 T: per bit i, J[i]=1 toggles bit i, J[i]=0 holds it.
- MODE 010 LOAD: Q ← D, loaded unmodified even if D ≥ MODULUS.
- MODE 011 UP: if Q ≥ MODULUS-1, Q ← 0 (SATURATE=0) or Q holds (SATURATE=1), and EVT is set next cycle. Otherwise Q ← Q+1.
- MODE 100 DOWN: if Q == 0, Q ← MODULUS-1 (SATURATE=0) or Q holds (SATURATE=1), and EVT is set next cycle. Otherwise Q ← Q-1, except that Q ≥ MODULUS loads MODULUS-1 with no EVT.
- MODE 101–111 reserved: Q holds, EVT=0.
- TC = (MODE==011 && Q ≥ MODULUS-1) || (MODE==100 && Q==0). TC is 0 in other modes and is not gated by EN.
- Arithmetic is WIDTH bits unsigned; MODULUS-1 is computed in WIDTH bits. With MODULUS=2**WIDTH, wrap equals natural overflow.
- EVT is registered: it is 1 for exactly the cycle after an enabled terminal-step update, otherwise 0. It also pulses on each enabled cycle while saturated.

## Timing
- All Q/EVT updates occur on the rising edge of CK; latency from input to Q is one cycle.
- Reset: RESET=1 at an edge gives Q=0, Q_=all ones, EVT=0. RESET has priority over EN and MODE. Reset mid-count discards the in-progress value, and counting resumes from 0 the cycle after RESET falls.
- EN=0 at an edge: Q holds and EVT=0.
- MODE or inputs changing between edges has no effect until the next edge. A mode change takes effect on the first edge where the new MODE is sampled, with no pipeline bubble.
- TC and Q_ are combinational from Q/MODE, valid in the same cycle.

## Test plan
- Reset/JK: RESET for 1 cycle gives Q=0x00, Q_=0xFF, EVT=0. Then JK with J=0xF0, K=0x0F gives Q=0xF0. J=K=0xFF gives Q=0x0F. J=K=0 holds 0x0F.
- T and load: LOAD D=0xA5 gives Q=0xA5. T mode J=0x0F gives 0xAA. EN=0 with J=0xFF holds 0xAA for 3 cycles.
- Wrap up, MODULUS=10: load 7, UP gives 8, 9 (TC=1), then 0 with EVT=1 for one cycle, then 1 with EVT=0.
- Wrap down, MODULUS=10: from 1, DOWN gives 0 (TC=1), then 9 with EVT=1. Load 12 then DOWN gives 9 with EVT=0.
- Saturate, SATURATE=1, MODULUS=10: UP from 8 gives 9, 9, 9 with EVT=1 on each cycle after the first 9. DOWN from 0 holds 0.
- Reset mid-count: UP at Q=5 with RESET asserted gives Q=0 the next cycle despite EN=1. With RESET deasserted, 1 then 2. WIDTH=1 instance toggles 0/1 in UP mode with EVT every other cycle.
